ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage MIPS pipeline: the consumer side of the ID/EX pipeline register. It takes the registered ID/EX control and data bundle, selects operands and the destination register, and computes the ALU result. Single-cycle ops use a combinational ALU; MUL uses an iterative 32-cycle shift-add unit that stalls the front of the pipe. Results are registered into the EX/MEM bundle.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits.
- Clk  in  1  pipeline clock, rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- Valid_EX  in  1  ID/EX slot holds a real instruction; 0 = bubble.
- Flush  in  1  kill the instruction presented this cycle (branch/jump redirect).
- RegWrite_EX, ALUSrc_EX, RegDst_EX, MemWrite_EX, MemRead_EX, MemToReg_EX  in  1 each  control from ID/EX.
- ALUOp_EX  in  4  operation select, encoding below.
- readData1_EX, readData2_EX  in  32  rs and rt values.
- signExtend_EX  in  32  sign-extended immediate.
- RtData_EX, RdData_EX  in  5  rt and rd indices.
- shamt_out  in  5  shift amount.
- BHC_EX  in  2  byte/half/word access control.
- Stall  out  1  hold PC, IF/ID and ID/EX this cycle.
- Valid_MEM  out  1  EX/MEM slot valid.
- RegWrite_MEM, MemWrite_MEM, MemRead_MEM, MemToReg_MEM  out  1 each  forwarded control.
- ALUResult_MEM  out  32  result / memory address.
- StoreData_MEM  out  32  readData2_EX captured with the instruction.
- WriteReg_MEM  out  5  destination index.
- BHC_MEM  out  2  forwarded access control.

## Operation
- A = readData1_EX; B = ALUSrc_EX ? signExtend_EX : readData2_EX; dest = RegDst_EX ? RdData_EX : RtData_EX.
- ALUOp: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed, 1/0), 7 SLL B by shamt, 8 SRL, 9 SRA, 10 MUL (low 32 bits of A*B), 11 LUI (B<<16), 12-15 result 0. ADD/SUB wrap mod 2^32, no overflow flag.
- Accept = Valid_EX & ~Flush & state IDLE. Non-accepted cycle in IDLE loads a bubble: Valid_MEM, RegWrite_MEM, MemWrite_MEM, MemRead_MEM = 0; data outputs hold.
- FSM IDLE/BUSY.
  - IDLE, accept, ALUOp != 10: register result and fields next edge; stay IDLE.
  - IDLE, accept, ALUOp == 10: latch A, B, dest, control; acc=0; cnt=0; go BUSY; bubble to EX/MEM.
  - BUSY: each edge acc += B[cnt] ? (A << cnt) : 0; cnt++. Edge at cnt==31 writes final acc and latched fields to EX/MEM with Valid_MEM=1, returns to IDLE. Other BUSY edges load bubbles.
- Stall (combinational) = (IDLE & accept & ALUOp==10) | (BUSY & cnt != 31); forced 0 while Reset high.
- In BUSY, all ID/EX inputs and Flush are ignored (the held MUL is older than any redirect).

## Timing
- Reset: state IDLE, cnt 0, acc 0, every EX/MEM output 0, Stall 0. Reset during BUSY aborts the MUL; no result is ever produced.
- Single-cycle op: latency 1 edge, throughput 1/cycle.
- MUL presented at cycle 0: Stall high cycles 0-31, low at cycle 32. Result valid after edge 32 (cycle 33). Next instruction is loaded into ID/EX on that same edge and accepted in cycle 33.
- Flush with Valid_EX in IDLE: bubble; a flushed MUL never raises Stall.
- Valid_EX=0 with ALUOp==10: no stall, bubble.

## Test plan
- Reset mid-stream: assert Reset asynchronously between edges -> all outputs 0 immediately, Stall 0.
- ADD A=0x7FFFFFFF, B=1 (ALUSrc=0, RegDst=1, Rd=5) -> next cycle ALUResult_MEM=0x80000000, WriteReg_MEM=5, Valid_MEM=1; SLT -5 vs 3 -> 1; SRA 0x80000000 by shamt 4 -> 0xF8000000.
- MUL 0xFFFFFFFF x 0x00000003, then ADD queued behind -> Stall high exactly 32 cycles, MUL result 0xFFFFFFFD valid 33 cycles after presentation, ADD result on the next cycle, no duplicate MUL.
- Flush on a valid SW (MemWrite=1) -> Valid_MEM=0, MemWrite_MEM=0; Flush on a MUL -> Stall stays 0.
- Flush pulsed during MUL BUSY -> ignored; MUL result 6 (2x3) still written.
- Reset at BUSY cnt=10 then new ADD 1+1 -> no MUL output ever; ADD yields 2 with Valid_MEM=1.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage, combinational ALU plus iterative 32-cycle shift-add multiplier
module ex_stage (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Valid_EX,
    input  logic        Flush,
    input  logic        RegWrite_EX,
    input  logic        ALUSrc_EX,
    input  logic        RegDst_EX,
    input  logic        MemWrite_EX,
    input  logic        MemRead_EX,
    input  logic        MemToReg_EX,
    input  logic [3:0]  ALUOp_EX,
    input  logic [31:0] readData1_EX,
    input  logic [31:0] readData2_EX,
    input  logic [31:0] signExtend_EX,
    input  logic [4:0]  RtData_EX,
    input  logic [4:0]  RdData_EX,
    input  logic [4:0]  shamt_out,
    input  logic [1:0]  BHC_EX,
    output logic        Stall,
    output logic        Valid_MEM,
    output logic        RegWrite_MEM,
    output logic        MemWrite_MEM,
    output logic        MemRead_MEM,
    output logic        MemToReg_MEM,
    output logic [31:0] ALUResult_MEM,
    output logic [31:0] StoreData_MEM,
    output logic [4:0]  WriteReg_MEM,
    output logic [1:0]  BHC_MEM
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t r_state, w_next;
    logic [4:0]  r_cnt, r_dest;
    logic [31:0] r_acc, r_a, r_b, r_store;
    logic        r_rw, r_mw, r_mr, r_m2r;
    logic [1:0]  r_bhc;
    logic [31:0] w_b, w_alu, w_acc_next;
    logic [4:0]  w_dest;
    logic        w_accept, w_is_mul, w_single, w_start, w_last;
    assign w_b        = ALUSrc_EX ? signExtend_EX : readData2_EX;
    assign w_dest     = RegDst_EX ? RdData_EX : RtData_EX;
    assign w_accept   = Valid_EX & ~Flush & (r_state == IDLE);
    assign w_is_mul   = ALUOp_EX == 4'd10;
    assign w_single   = w_accept & ~w_is_mul;
    assign w_start    = w_accept & w_is_mul;
    assign w_last     = (r_state == BUSY) & (r_cnt == 5'd31);
    assign w_acc_next = r_acc + (r_b[r_cnt] ? (r_a << r_cnt) : 32'd0);
    // Single-cycle ALU; MUL and unused codes produce 0 here
    always_comb begin
        case (ALUOp_EX)
            4'd0:    w_alu = readData1_EX + w_b;
            4'd1:    w_alu = readData1_EX - w_b;
            4'd2:    w_alu = readData1_EX & w_b;
            4'd3:    w_alu = readData1_EX | w_b;
            4'd4:    w_alu = readData1_EX ^ w_b;
            4'd5:    w_alu = ~(readData1_EX | w_b);
            4'd6:    w_alu = {31'd0, $signed(readData1_EX) < $signed(w_b)};
            4'd7:    w_alu = w_b << shamt_out;
            4'd8:    w_alu = w_b >> shamt_out;
            4'd9:    w_alu = $signed(w_b) >>> shamt_out;
            4'd11:   w_alu = w_b << 16;
            default: w_alu = 32'd0;
        endcase
    end
    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    // Next state: a MUL start enters BUSY, the cnt==31 edge returns to IDLE
    always_comb begin
        w_next = r_state == IDLE ? (w_start ? BUSY : IDLE) : (w_last ? IDLE : BUSY);
    end
    // Stall holds the front of the pipe until the final MUL cycle
    always_comb begin
        Stall = ~Reset & (w_start | ((r_state == BUSY) & (r_cnt != 5'd31)));
    end
    // Multiplier operand latch and shift-add iteration
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cnt   <= 5'd0;
            r_acc   <= 32'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_dest  <= 5'd0;
            r_store <= 32'd0;
            r_rw    <= 1'b0;
            r_mw    <= 1'b0;
            r_mr    <= 1'b0;
            r_m2r   <= 1'b0;
            r_bhc   <= 2'd0;
        end else if (w_start) begin
            r_cnt   <= 5'd0;
            r_acc   <= 32'd0;
            r_a     <= readData1_EX;
            r_b     <= w_b;
            r_dest  <= w_dest;
            r_store <= readData2_EX;
            r_rw    <= RegWrite_EX;
            r_mw    <= MemWrite_EX;
            r_mr    <= MemRead_EX;
            r_m2r   <= MemToReg_EX;
            r_bhc   <= BHC_EX;
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + 5'd1;
            r_acc <= w_acc_next;
        end
    end
    // EX/MEM register: bubbles clear the control bits, data fields hold
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Valid_MEM     <= 1'b0;
            RegWrite_MEM  <= 1'b0;
            MemWrite_MEM  <= 1'b0;
            MemRead_MEM   <= 1'b0;
            MemToReg_MEM  <= 1'b0;
            ALUResult_MEM <= 32'd0;
            StoreData_MEM <= 32'd0;
            WriteReg_MEM  <= 5'd0;
            BHC_MEM       <= 2'd0;
        end else begin
            Valid_MEM    <= w_single | w_last;
            RegWrite_MEM <= w_single ? RegWrite_EX : w_last & r_rw;
            MemWrite_MEM <= w_single ? MemWrite_EX : w_last & r_mw;
            MemRead_MEM  <= w_single ? MemRead_EX : w_last & r_mr;
            if (w_single) begin
                MemToReg_MEM  <= MemToReg_EX;
                ALUResult_MEM <= w_alu;
                StoreData_MEM <= readData2_EX;
                WriteReg_MEM  <= w_dest;
                BHC_MEM       <= BHC_EX;
            end else if (w_last) begin
                MemToReg_MEM  <= r_m2r;
                ALUResult_MEM <= w_acc_next;
                StoreData_MEM <= r_store;
                WriteReg_MEM  <= r_dest;
                BHC_MEM       <= r_bhc;
            end
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for the execute stage
module tb_ex_stage;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Valid_EX, Flush, RegWrite_EX, ALUSrc_EX, RegDst_EX, MemWrite_EX, MemRead_EX, MemToReg_EX;
    logic [3:0]  ALUOp_EX;
    logic [31:0] readData1_EX, readData2_EX, signExtend_EX;
    logic [4:0]  RtData_EX, RdData_EX, shamt_out;
    logic [1:0]  BHC_EX;
    logic        Stall, Valid_MEM, RegWrite_MEM, MemWrite_MEM, MemRead_MEM, MemToReg_MEM;
    logic [31:0] ALUResult_MEM, StoreData_MEM;
    logic [4:0]  WriteReg_MEM;
    logic [1:0]  BHC_MEM;
    int          n_checks = 0;
    int          n_fail = 0;

    ex_stage dut (
        .Clk(Clk), .Reset(Reset), .Valid_EX(Valid_EX), .Flush(Flush),
        .RegWrite_EX(RegWrite_EX), .ALUSrc_EX(ALUSrc_EX), .RegDst_EX(RegDst_EX),
        .MemWrite_EX(MemWrite_EX), .MemRead_EX(MemRead_EX), .MemToReg_EX(MemToReg_EX),
        .ALUOp_EX(ALUOp_EX), .readData1_EX(readData1_EX), .readData2_EX(readData2_EX),
        .signExtend_EX(signExtend_EX), .RtData_EX(RtData_EX), .RdData_EX(RdData_EX),
        .shamt_out(shamt_out), .BHC_EX(BHC_EX), .Stall(Stall), .Valid_MEM(Valid_MEM),
        .RegWrite_MEM(RegWrite_MEM), .MemWrite_MEM(MemWrite_MEM), .MemRead_MEM(MemRead_MEM),
        .MemToReg_MEM(MemToReg_MEM), .ALUResult_MEM(ALUResult_MEM), .StoreData_MEM(StoreData_MEM),
        .WriteReg_MEM(WriteReg_MEM), .BHC_MEM(BHC_MEM)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [4:0] sh);
        Valid_EX = 1'b1; Flush = 1'b0; RegWrite_EX = 1'b1; ALUSrc_EX = 1'b0; RegDst_EX = 1'b1;
        MemWrite_EX = 1'b0; MemRead_EX = 1'b0; MemToReg_EX = 1'b0; ALUOp_EX = op;
        readData1_EX = a; readData2_EX = b; signExtend_EX = 32'd0; RtData_EX = 5'd0;
        RdData_EX = rd; shamt_out = sh; BHC_EX = 2'b11;
    endtask

    task automatic bubble();
        issue(4'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        Valid_EX = 1'b0;
    endtask

    initial begin
        int stalls;
        int seen;
        issue(4'd10, 32'd7, 32'd7, 5'd1, 5'd0);
        #1;
        chk("stall_in_reset", {31'd0, Stall}, 32'd0);
        tick();
        tick();
        chk("rst_valid", {31'd0, Valid_MEM}, 32'd0);
        chk("rst_result", ALUResult_MEM, 32'd0);
        chk("rst_ctrl", {27'd0, RegWrite_MEM, MemWrite_MEM, MemRead_MEM, MemToReg_MEM, Stall}, 32'd0);
        chk("rst_fields", {StoreData_MEM[24:0], WriteReg_MEM, BHC_MEM}, 32'd0);
        Reset = 1'b0;
        issue(4'd0, 32'h7FFFFFFF, 32'd1, 5'd5, 5'd0);
        RtData_EX = 5'd3;
        tick();
        chk("add_result", ALUResult_MEM, 32'h80000000);
        chk("add_wreg", {27'd0, WriteReg_MEM}, 32'd5);
        chk("add_valid", {30'd0, Valid_MEM, RegWrite_MEM}, 32'd3);
        issue(4'd6, 32'hFFFFFFFB, 32'd0, 5'd0, 5'd0);
        ALUSrc_EX = 1'b1; signExtend_EX = 32'd3; RegDst_EX = 1'b0; RtData_EX = 5'd7;
        tick();
        chk("slt_result", ALUResult_MEM, 32'd1);
        chk("slt_wreg", {27'd0, WriteReg_MEM}, 32'd7);
        issue(4'd9, 32'd0, 32'h80000000, 5'd8, 5'd4);
        tick();
        chk("sra_result", ALUResult_MEM, 32'hF8000000);
        issue(4'd1, 32'd3, 32'd5, 5'd10, 5'd0);
        tick();
        chk("sub_result", ALUResult_MEM, 32'hFFFFFFFE);
        issue(4'd11, 32'd0, 32'd0, 5'd11, 5'd0);
        ALUSrc_EX = 1'b1; signExtend_EX = 32'h00001234;
        tick();
        chk("lui_result", ALUResult_MEM, 32'h12340000);
        issue(4'd7, 32'd0, 32'd1, 5'd12, 5'd31);
        tick();
        chk("sll_result", ALUResult_MEM, 32'h80000000);
        issue(4'd13, 32'd5, 32'd5, 5'd1, 5'd0);
        tick();
        chk("op13_result", ALUResult_MEM, 32'd0);
        issue(4'd10, 32'd5, 32'd5, 5'd1, 5'd0);
        Valid_EX = 1'b0;
        #1;
        chk("inv_mul_stall", {31'd0, Stall}, 32'd0);
        tick();
        chk("inv_mul_valid", {31'd0, Valid_MEM}, 32'd0);
        chk("bubble_hold", ALUResult_MEM, 32'd0);
        issue(4'd0, 32'd100, 32'hDEADBEEF, 5'd0, 5'd0);
        ALUSrc_EX = 1'b1; signExtend_EX = 32'd8; MemWrite_EX = 1'b1; RegWrite_EX = 1'b0; BHC_EX = 2'b01;
        tick();
        chk("sw_addr", ALUResult_MEM, 32'd108);
        chk("sw_data", StoreData_MEM, 32'hDEADBEEF);
        chk("sw_ctrl", {28'd0, Valid_MEM, MemWrite_MEM, RegWrite_MEM, MemRead_MEM}, 32'hC);
        chk("sw_bhc", {30'd0, BHC_MEM}, 32'd1);
        signExtend_EX = 32'd16; Flush = 1'b1;
        tick();
        chk("flush_sw_ctrl", {30'd0, Valid_MEM, MemWrite_MEM}, 32'd0);
        chk("flush_sw_hold", ALUResult_MEM, 32'd108);
        issue(4'd10, 32'd2, 32'd3, 5'd1, 5'd0);
        Flush = 1'b1;
        #1;
        chk("flush_mul_stall", {31'd0, Stall}, 32'd0);
        tick();
        chk("flush_mul_stall2", {31'd0, Stall}, 32'd0);
        chk("flush_mul_valid", {31'd0, Valid_MEM}, 32'd0);
        issue(4'd10, 32'hFFFFFFFF, 32'd3, 5'd9, 5'd0);
        #1;
        stalls = 0;
        seen = 0;
        while (Stall && stalls < 40) begin
            stalls++;
            tick();
            if (Valid_MEM) seen++;
        end
        chk("mul_stall_cycles", stalls, 32'd32);
        chk("mul_no_early_out", seen, 32'd0);
        tick();
        chk("mul_result", ALUResult_MEM, 32'hFFFFFFFD);
        chk("mul_wreg_valid", {26'd0, Valid_MEM, WriteReg_MEM}, {26'd0, 1'b1, 5'd9});
        issue(4'd0, 32'd10, 32'd20, 5'd4, 5'd0);
        #1;
        chk("after_mul_stall", {31'd0, Stall}, 32'd0);
        tick();
        chk("queued_add", ALUResult_MEM, 32'd30);
        chk("queued_add_wreg", {26'd0, Valid_MEM, WriteReg_MEM}, {26'd0, 1'b1, 5'd4});
        bubble();
        tick();
        chk("no_dup_mul", {31'd0, Valid_MEM}, 32'd0);
        issue(4'd10, 32'd2, 32'd3, 5'd6, 5'd0);
        #1;
        stalls = 0;
        while (Stall && stalls < 40) begin
            stalls++;
            tick();
            Flush = stalls[0];
        end
        chk("busy_flush_stalls", stalls, 32'd32);
        tick();
        chk("busy_flush_result", ALUResult_MEM, 32'd6);
        chk("busy_flush_valid", {26'd0, Valid_MEM, WriteReg_MEM}, {26'd0, 1'b1, 5'd6});
        issue(4'd10, 32'd7, 32'd7, 5'd13, 5'd0);
        for (int i = 0; i < 11; i++) tick();
        #2;
        Reset = 1'b1;
        #1;
        chk("async_rst_result", ALUResult_MEM, 32'd0);
        chk("async_rst_ctrl", {26'd0, Valid_MEM, Stall, WriteReg_MEM[3:0]}, 32'd0);
        #1;
        Reset = 1'b0;
        issue(4'd0, 32'd1, 32'd1, 5'd2, 5'd0);
        tick();
        chk("post_rst_add", ALUResult_MEM, 32'd2);
        chk("post_rst_valid", {26'd0, Valid_MEM, WriteReg_MEM}, {26'd0, 1'b1, 5'd2});
        bubble();
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Valid_MEM || Stall) seen++;
        end
        chk("no_aborted_mul", seen, 32'd0);
        chk("final_hold", ALUResult_MEM, 32'd2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
